// File: rtl/ni_packetizer.sv
// NI transmit stage: serialises one PE packet request into head/body/tail flits for the router.
// Optional build macro NI_PKT_COUNT_EN adds a wrapping count of completed packets on pkt_count.
module ni_packetizer #(
   parameter logic [1:0] NODE_ID = 2'b00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pe_valid,
   output logic        pe_ready,
   input  logic [1:0]  pe_dest,
   input  logic [1:0]  pe_len,
   input  logic [23:0] pe_data,
   input  logic        free,
   output logic [7:0]  flit_out,
   output logic        busy
`ifdef NI_PKT_COUNT_EN
   ,output logic [7:0] pkt_count
`endif
);

   localparam int unsigned DATA_W  = 24;
   localparam int unsigned CHUNK_W = 6;
   localparam int unsigned LEN_W   = 2;
   localparam int unsigned DEST_W  = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      HEAD    = 2'b01,
      PAYLOAD = 2'b10
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [DEST_W-1:0]   dest_q, dest_d;
   logic [LEN_W-1:0]    rem_q, rem_d;
   logic                vc_q, vc_d;

   // State and packet registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         dest_q  <= '0;
         rem_q   <= '0;
         vc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         dest_q  <= dest_d;
         rem_q   <= rem_d;
         vc_q    <= vc_d;
      end
   end

   // Next state and flit formatting; flit_out depends only on registered state
   always_comb begin
      state_d  = state_q;
      data_d   = data_q;
      dest_d   = dest_q;
      rem_d    = rem_q;
      vc_d     = vc_q;
      flit_out = 8'h00;
      busy     = (state_q != IDLE);
      pe_ready = (state_q == IDLE) && !rst;

      unique case (state_q)
         IDLE: begin
            if (pe_valid) begin
               data_d  = pe_data;
               dest_d  = pe_dest;
               rem_d   = pe_len;
               state_d = HEAD;
            end
         end
         HEAD: begin
            flit_out = {2'b01, dest_q, NODE_ID, 1'b0, vc_q};
            if (free) begin
               state_d = PAYLOAD;
            end
         end
         PAYLOAD: begin
            flit_out = {(rem_q == '0) ? 2'b11 : 2'b10, data_q[CHUNK_W-1:0]};
            if (free) begin
               if (rem_q == '0) begin
                  state_d = IDLE;
                  vc_d    = ~vc_q;
               end else begin
                  data_d = data_q >> CHUNK_W;
                  rem_d  = LEN_W'(rem_q - 2'd1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef NI_PKT_COUNT_EN
   logic tail_acc;
   assign tail_acc = (state_q == PAYLOAD) && free && (rem_q == '0);

   // Completed-packet counter, wraps naturally at 8 bits
   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_count <= 8'd0;
      end else if (tail_acc) begin
         pkt_count <= 8'(pkt_count + 8'd1);
      end
   end
`endif

endmodule

// File: tb/tb_ni_packetizer.sv
// Directed bench for ni_packetizer with an expected-flit scoreboard.
// Build with NI_PKT_COUNT_EN defined to also cover pkt_count.
module tb_ni_packetizer;

   localparam logic [1:0] NODE = 2'b00;

   logic        clk = 1'b0;
   logic        rst;
   logic        pe_valid;
   logic        pe_ready;
   logic [1:0]  pe_dest;
   logic [1:0]  pe_len;
   logic [23:0] pe_data;
   logic        free;
   logic [7:0]  flit_out;
   logic        busy;
`ifdef NI_PKT_COUNT_EN
   logic [7:0]  pkt_count;
`endif

   int         checks = 0;
   int         passes = 0;
   logic [7:0] q[$];
   logic       exp_vc = 1'b0;
   int         exp_cnt = 0;

   ni_packetizer #(.NODE_ID(NODE)) dut (
      .clk      (clk),
      .rst      (rst),
      .pe_valid (pe_valid),
      .pe_ready (pe_ready),
      .pe_dest  (pe_dest),
      .pe_len   (pe_len),
      .pe_data  (pe_data),
      .free     (free),
      .flit_out (flit_out),
      .busy     (busy)
`ifdef NI_PKT_COUNT_EN
      ,.pkt_count (pkt_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // One cycle: apply free, score any accepted flit, then advance past the edge
   task automatic step(input logic f);
      logic [7:0] e;
      free = f;
      if (f && flit_out !== 8'h00) begin
         if (q.size() == 0) begin
            chk("unexpected_flit", {24'h0, flit_out}, 32'h0);
         end else begin
            e = q.pop_front();
            chk("flit_seq", {24'h0, flit_out}, {24'h0, e});
            if (e[7:6] == 2'b11) begin
               exp_vc = ~exp_vc;
               exp_cnt++;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      q.delete();
      exp_vc  = 1'b0;
      exp_cnt = 0;
   endtask

   // Present a request for one cycle (block must be idle) and queue its flits
   task automatic request(input logic [1:0] d, input logic [1:0] l, input logic [23:0] data);
      pe_valid = 1'b1;
      pe_dest  = d;
      pe_len   = l;
      pe_data  = data;
      chk("pe_ready_accept", {31'h0, pe_ready}, 32'h1);
      q.push_back({2'b01, d, NODE, 1'b0, exp_vc});
      for (int i = 0; i <= int'(l); i++) begin
         q.push_back({(i == int'(l)) ? 2'b11 : 2'b10, data[6*i +: 6]});
      end
      step(1'b1);
      pe_valid = 1'b0;
      pe_data  = 24'($urandom);
      pe_dest  = 2'($urandom);
      pe_len   = 2'($urandom);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_flit"}, {24'h0, flit_out}, 32'h0);
      chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
      chk({tag, "_ready"}, {31'h0, pe_ready}, 32'h1);
      chk({tag, "_queue"}, q.size(), 32'h0);
   endtask

   initial begin
      rst      = 1'b1;
      pe_valid = 1'b0;
      pe_dest  = 2'b00;
      pe_len   = 2'b00;
      pe_data  = 24'h0;
      free     = 1'b0;
      @(posedge clk);
      #1;
      step(1'b0);
      chk("reset_flit", {24'h0, flit_out}, 32'h0);
      chk("reset_busy", {31'h0, busy}, 32'h0);
      chk("reset_ready", {31'h0, pe_ready}, 32'h0);
      rst = 1'b0;
      #1;
      chk("ready_after_reset", {31'h0, pe_ready}, 32'h1);

      // Idle for 10 cycles
      for (int i = 0; i < 10; i++) begin
         chk("idle_flit", {24'h0, flit_out}, 32'h0);
         chk("idle_ready", {31'h0, pe_ready}, 32'h1);
         chk("idle_busy", {31'h0, busy}, 32'h0);
         step(1'b1);
      end

      // Basic packet: 70, 85, FF then idle
      request(2'b11, 2'd1, 24'h000FC5);
      chk("head_latency", {24'h0, flit_out}, 32'h70);
      chk("busy_in_head", {31'h0, busy}, 32'h1);
      chk("ready_in_head", {31'h0, pe_ready}, 32'h0);
      step(1'b1);
      chk("body_flit", {24'h0, flit_out}, 32'h85);
      step(1'b1);
      chk("tail_flit", {24'h0, flit_out}, 32'hFF);
      step(1'b1);
      check_idle("after_pkt1");

      // Same request with free low for 3 cycles on the head; vc is now 1
      request(2'b11, 2'd1, 24'h000FC5);
      for (int i = 0; i < 3; i++) begin
         chk("head_hold", {24'h0, flit_out}, 32'h71);
         step(1'b0);
      end
      chk("head_hold_last", {24'h0, flit_out}, 32'h71);
      repeat (3) step(1'b1);
      check_idle("after_pkt2");

      // Back-to-back len=0 packets, one idle cycle between them
      request(2'b01, 2'd0, 24'h00002A);
      chk("b2b_head0", {24'h0, flit_out}, 32'h50);
      step(1'b1);
      chk("b2b_tail0", {24'h0, flit_out}, 32'hEA);
      step(1'b1);
      check_idle("b2b_gap");
      request(2'b01, 2'd0, 24'h000015);
      chk("b2b_head1", {24'h0, flit_out}, 32'h51);
      step(1'b1);
      step(1'b1);
      check_idle("after_b2b");

      // free toggling each cycle, pe_valid held high while busy is ignored
      request(2'b10, 2'd3, 24'hA5C3E1);
      pe_valid = 1'b1;
      pe_dest  = 2'b01;
      pe_len   = 2'd0;
      for (int i = 0; i < 10; i++) begin
         if (i == 9) pe_valid = 1'b0;
         step(1'(i % 2));
      end
      check_idle("after_toggle");

      // Reset while the second of four payload flits is presented
      request(2'b10, 2'd3, 24'h123456);
      step(1'b1);
      step(1'b1);
      chk("second_payload", {24'h0, flit_out}, {24'h0, q[0]});
      rst = 1'b1;
      step(1'b0);
      model_reset();
      chk("rst_mid_flit", {24'h0, flit_out}, 32'h0);
      chk("rst_mid_busy", {31'h0, busy}, 32'h0);
      chk("rst_mid_ready", {31'h0, pe_ready}, 32'h0);
      rst = 1'b0;
      #1;
      request(2'b10, 2'd0, 24'h00003F);
      chk("head_vc0_after_reset", {24'h0, flit_out}, 32'h60);
      step(1'b1);
      step(1'b1);
      check_idle("after_reset_pkt");

`ifdef NI_PKT_COUNT_EN
      rst = 1'b1;
      step(1'b0);
      model_reset();
      chk("pkt_count_reset", {24'h0, pkt_count}, 32'h0);
      rst = 1'b0;
      #1;
      for (int i = 0; i < 257; i++) begin
         request(2'b01, 2'd0, 24'($urandom));
         pe_valid = 1'b1;
         step(1'b1);
         step(1'b1);
         pe_valid = 1'b0;
      end
      chk("pkt_count_wrap", {24'h0, pkt_count}, 32'h1);
      chk("pkt_count_model", {24'h0, pkt_count}, {24'h0, 8'(exp_cnt)});
      check_idle("after_count");
`endif

      chk("scoreboard_empty", q.size(), 32'h0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
